rca_bist: RTL
=============

# rca_bist

Built-in self-test initiator for the clocked 4-bit ripple-carry adder. On a `run` pulse it exhaustively walks all 256 operand pairs. For each pair it:
- drives the adder's level-sensitive `start`/`A`/`B` request side;
- waits a fixed settling window;
- samples the adder's registered `S`/`Cout`;
- compares them against a golden `A+B`.

It reports error count, first failing vector and pass/fail. It sits beside the adder in the datapath test wrapper.

## Interface
Parameters:
- `START_HI`, default 2: cycles `start` is held high per vector; must be ≥2 so the adder's two-stage edge detector sees the rise.
- `WAIT_CYCLES`, default 10: cycles `start` is held low before sampling; must be ≥8 so the adder result is settled and ≥2 so the next rising edge is detectable.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: one-cycle start-of-test request.
- `start` out 1: request level to adder.
- `A` out 4: operand to adder.
- `B` out 4: operand to adder.
- `S` in 4: adder sum.
- `Cout` in 1: adder carry-out.
- `busy` out 1: test in progress.
- `done` out 1: test complete; held until next accepted `run`.
- `pass` out 1: `done` and `err_cnt == 0`.
- `err_cnt` out 9: number of mismatching vectors, 0..256.
- `fail_a` out 4: A of first mismatch.
- `fail_b` out 4: B of first mismatch.

## Operation
- States:
  - IDLE
  - ASSERT (`start=1`)
  - WAIT (`start=0`)
  - CHECK (`start=0`, compare)
  - DONE
- 8-bit vector index `idx`; `A = idx[7:4]`, `B = idx[3:0]`. A/B stay stable from ASSERT entry through CHECK of the same vector.
- IDLE/DONE + `run` → ASSERT; on the same edge:
  - `idx` ← 0;
  - `err_cnt` ← 0;
  - `fail_a`/`fail_b` ← 0;
  - `done` ← 0.
- ASSERT → WAIT after `START_HI` cycles.
- WAIT → CHECK after `WAIT_CYCLES` cycles.
- CHECK behaviour:
  - Compare `{Cout,S}` with 5-bit `A+B` (zero-extended 4-bit operands, no carry-in).
  - On mismatch, `err_cnt` increments. If it was 0, `fail_a`/`fail_b` ← A/B.
  - If `idx == 255` → DONE. Otherwise `idx` wraps/increments → ASSERT.
- `err_cnt` cannot overflow (maximum 256 fits 9 bits).
- `run` in ASSERT/WAIT/CHECK is ignored.
- `busy` is 1 in ASSERT, WAIT and CHECK.
- Reset values: `start`=0, `A`=0, `B`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_a`=0, `fail_b`=0; state IDLE.
- Reset asserted mid-test aborts immediately to the reset values. No result is retained.

## Timing
- `run` sampled high at edge t0 → `start`=1 and `busy`=1 from t0 until t0+`START_HI`.
- Sampling takes place in the CHECK cycle, i.e. `START_HI`+`WAIT_CYCLES` cycles after `start` rose. Defaults: 12 cycles after rise; the adder needs ≤8.
- Vector period = `START_HI`+`WAIT_CYCLES`+1 (default 13).
- Full run = 256 × period (default 3328 cycles) from the `run` edge to `done`=1.
- `done`, `pass` and the final `err_cnt` update on the same edge as the last CHECK exit.
- `start` low time between vectors = `WAIT_CYCLES`+1 ≥ 3 cycles, which guarantees a fresh rising edge per vector.
- All outputs are registered; there is no combinational path from `S`/`Cout` to outputs.

## Configuration
- `RCA_BIST_STOP_ON_FAIL_EN` defined: the first mismatch in CHECK goes directly to DONE with `err_cnt`=1, `fail_a`/`fail_b` captured, and `pass`=0.
- Not defined: the full 256-vector sweep always completes and counts every mismatch.

## Structure
- `rca_bist_pkg` holds:
  - state enum (IDLE, ASSERT, WAIT, CHECK, DONE);
  - `RCA_W`=4;
  - `IDX_W`=8;
  - `ERR_W`=9;
  - `LAST_IDX`=8'hFF.
- One sub-module, `rca_bist_timer`: loadable down-counter asserting `expire` after N cycles. It is shared by ASSERT and WAIT.
- The golden sum is inline combinational logic.

## Test plan
- Bench-model adder that is correct, `run` pulse → `done` at cycle 3328, `pass`=1, `err_cnt`=0, `start` rises 256 times.
- Model with `S[0]` stuck-at-0 → `err_cnt`=128, `fail_a`=0, `fail_b`=1, `pass`=0.
- Model with `Cout` stuck-at-0 → `err_cnt`=120, `fail_a`=1, `fail_b`=15.
- `rst_n` pulsed low at vector 40 → all outputs are at their reset values within the reset cycle. A following `run` completes a clean full sweep with `pass`=1.
- `run` re-pulsed during WAIT of vector 5 → ignored; sweep timing unchanged; `done` still at cycle 3328.
- With `RCA_BIST_STOP_ON_FAIL_EN` and `S[0]` stuck-at-0 → `done` at cycle 26 (end of vector 1), `err_cnt`=1, `fail_a`=0, `fail_b`=1.

Source files
------------

// File: rtl/rca_bist_pkg.sv
// rtl/rca_bist_pkg.sv - shared types and constants for the ripple-carry adder BIST
//
// Contents:
//   state_t  : BIST sequencer states (IDLE, ASSERT, WAIT, CHECK, DONE)
//   RCA_W    : adder operand width
//   IDX_W    : vector index width (two concatenated operands)
//   ERR_W    : error counter width (holds 0..256)
//   LAST_IDX : index of the final operand pair
package rca_bist_pkg;

    localparam int RCA_W = 4;
    localparam int IDX_W = 8;
    localparam int ERR_W = 9;
    localparam logic [IDX_W-1:0] LAST_IDX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ASSERT = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/rca_bist_timer.sv
// rtl/rca_bist_timer.sv - loadable down-counter flagging expiry after N cycles
//
// Ports:
//   clk      in        clock
//   rst_n    in        asynchronous active-low reset
//   load     in        load a new interval (takes effect on this edge)
//   load_val in  [W]   interval length N in cycles, N >= 1
//   expire   out       high during the Nth cycle after the load edge
module rca_bist_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Loading N-1 makes expire rise in the Nth cycle, so a state that loads
    // on entry and leaves on expire occupies exactly N cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/rca_bist.sv
// rtl/rca_bist.sv - exhaustive built-in self-test initiator for the 4-bit ripple-carry adder
//
// Parameters:
//   START_HI    cycles start is held high per vector (>= 2)
//   WAIT_CYCLES cycles start is held low before sampling (>= 8)
// Optional build macro:
//   RCA_BIST_STOP_ON_FAIL_EN  stop at the first mismatching vector
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               one-cycle test request (ignored while busy)
//   start, A, B       request level and operands driven to the adder
//   S, Cout           registered adder result
//   busy, done, pass  test status; done/pass held until the next accepted run
//   err_cnt           number of mismatching vectors
//   fail_a, fail_b    operands of the first mismatch
module rca_bist
    import rca_bist_pkg::*;
#(
    parameter int START_HI    = 2,
    parameter int WAIT_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             start,
    output logic [RCA_W-1:0] A,
    output logic [RCA_W-1:0] B,
    input  logic [RCA_W-1:0] S,
    input  logic             Cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [RCA_W-1:0] fail_a,
    output logic [RCA_W-1:0] fail_b
);

    localparam int TW = 16;

    state_t           state;
    logic [IDX_W-1:0] idx;

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_expire;

    logic [RCA_W:0]   golden;
    logic             mismatch;
    logic             accept_run;
    logic             last_vec;

    // Operands come straight from the index register, so they change only
    // at CHECK exit and stay stable for the whole vector.
    assign A = idx[IDX_W-1:RCA_W];
    assign B = idx[RCA_W-1:0];

    assign golden     = {1'b0, A} + {1'b0, B};
    assign mismatch   = ({Cout, S} != golden);
    assign accept_run = run && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef RCA_BIST_STOP_ON_FAIL_EN
    assign last_vec = (idx == LAST_IDX) || mismatch;
`else
    assign last_vec = (idx == LAST_IDX);
`endif

    // One timer serves both ASSERT and WAIT: it is reloaded with the next
    // interval on the edge that enters each of those states.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TW'(START_HI);
        if (accept_run) begin
            tmr_load = 1'b1;
        end else if ((state == ST_ASSERT) && tmr_expire) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(WAIT_CYCLES);
        end else if ((state == ST_CHECK) && !last_vec) begin
            tmr_load = 1'b1;
        end
    end

    rca_bist_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            start   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            fail_a  <= '0;
            fail_b  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (run) begin
                        state   <= ST_ASSERT;
                        idx     <= '0;
                        err_cnt <= '0;
                        fail_a  <= '0;
                        fail_b  <= '0;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        start   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (tmr_expire) begin
                        state <= ST_WAIT;
                        start <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (tmr_expire) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) begin
                            fail_a <= A;
                            fail_b <= B;
                        end
                    end
                    if (last_vec) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // The counter update above lands on this same edge,
                        // so the final verdict must include this vector.
                        pass  <= (err_cnt == '0) && !mismatch;
                    end else begin
                        state <= ST_ASSERT;
                        idx   <= idx + 1'b1;
                        start <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    start <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
